// File: rtl/dual_rail_driver_if.sv
// Operand and response handshakes between a producer/consumer and the dual-rail driver.
// The master modport is the side offering operands and accepting results.
interface dual_rail_driver_if;
  logic       op_valid;
  logic [3:0] op_data;
  logic       op_ready;
  logic       rsp_valid;
  logic       rsp_data;
  logic [3:0] rsp_op;
  logic       rsp_ready;

  modport master (
    output op_valid, op_data, rsp_ready,
    input  op_ready, rsp_valid, rsp_data, rsp_op
  );

  modport slave (
    input  op_valid, op_data, rsp_ready,
    output op_ready, rsp_valid, rsp_data, rsp_op
  );
endinterface

// File: rtl/dual_rail_driver.sv
// Drives a 4-bit operand onto dual-rail evaluator inputs, waits SETTLE cycles, returns eval_out.
// Define DR_SPACER_EN to insert a SPACER-cycle all-rails-low NULL phase after each response.
module dual_rail_driver #(
  parameter int SETTLE = 3,
  parameter int SPACER = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  dual_rail_driver_if.slave        bus,
  output logic [3:0]               rail_t,
  output logic [3:0]               rail_f,
  input  logic                     eval_out
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("dual_rail_driver: SETTLE must be 1..15");
  end
  if (SPACER < 1 || SPACER > 15) begin : g_bad_spacer
    $error("dual_rail_driver: SPACER must be 1..15");
  end

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
`ifdef DR_SPACER_EN
  localparam logic [3:0] SPACER_LOAD = 4'(SPACER - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RESP  = 2'd2
`ifdef DR_SPACER_EN
    , S_SPACER = 2'd3
`endif
  } state_t;

  state_t     state, state_n;
  logic [3:0] rail_t_n, rail_f_n;
  logic       rsp_valid_q, rsp_valid_n;
  logic       rsp_data_q, rsp_data_n;
  logic [3:0] rsp_op_q, rsp_op_n;
  logic [3:0] cnt, cnt_n;
  logic       op_ready_c;

  // The counter is shared between the settle wait and the spacer phase; both load then count to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rail_t      <= 4'b0000;
      rail_f      <= 4'b1111;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 1'b0;
      rsp_op_q    <= 4'b0000;
      cnt         <= 4'd0;
    end else begin
      state       <= state_n;
      rail_t      <= rail_t_n;
      rail_f      <= rail_f_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_data_q  <= rsp_data_n;
      rsp_op_q    <= rsp_op_n;
      cnt         <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    rail_t_n    = rail_t;
    rail_f_n    = rail_f;
    rsp_valid_n = rsp_valid_q;
    rsp_data_n  = rsp_data_q;
    rsp_op_n    = rsp_op_q;
    cnt_n       = cnt;
    op_ready_c  = 1'b0;
    unique case (state)
      S_IDLE: begin
        op_ready_c = 1'b1;
        if (bus.op_valid) begin
          rail_t_n = bus.op_data;
          rail_f_n = ~bus.op_data;
          rsp_op_n = bus.op_data;
          cnt_n    = SETTLE_LOAD;
          state_n  = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt == 4'd0) begin
          rsp_data_n  = eval_out;
          rsp_valid_n = 1'b1;
          state_n     = S_RESP;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_n = 1'b0;
`ifdef DR_SPACER_EN
          rail_t_n = 4'b0000;
          rail_f_n = 4'b0000;
          cnt_n    = SPACER_LOAD;
          state_n  = S_SPACER;
`else
          state_n  = S_IDLE;
`endif
        end
      end
`ifdef DR_SPACER_EN
      // Rails stay NULL on return to IDLE; the next accept edge drives fresh rails.
      S_SPACER: begin
        if (cnt == 4'd0) begin
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
`endif
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign bus.op_ready  = op_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_op    = rsp_op_q;

endmodule

// File: tb/tb_dual_rail_driver.sv
// Scoreboard bench for dual_rail_driver: one instance with SETTLE=3, one with SETTLE=1.
// Spacer scenario is compiled in when DR_SPACER_EN is defined.
module tb_dual_rail_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cycle = 0;
  int   checks = 0;
  int   failures = 0;
  logic inv_en = 1'b0;

`ifdef DR_SPACER_EN
  localparam bit SPACER_BUILD = 1'b1;
`else
  localparam bit SPACER_BUILD = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  dual_rail_driver_if bus3 ();
  dual_rail_driver_if bus1 ();
  logic [3:0] rt3, rf3, rt1, rf1;
  logic       ev3, ev1;
  logic [4:0] sb3[$];
  logic [4:0] sb1[$];

  // Independent evaluator reference: a&c | b&~d | ~a&~b&~d
  function automatic logic eval_model(input logic [3:0] x);
    logic a, b, c, d;
    {a, b, c, d} = x;
    return (a & c) | (b & ~d) | (~a & ~b & ~d);
  endfunction

  assign ev3 = eval_model(rt3);
  assign ev1 = eval_model(rt1);

  dual_rail_driver #(.SETTLE(3), .SPACER(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .rail_t(rt3), .rail_f(rf3), .eval_out(ev3));
  dual_rail_driver #(.SETTLE(1), .SPACER(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .rail_t(rt1), .rail_f(rf1), .eval_out(ev1));

  function automatic logic g_ready(input int s);
    return (s == 1) ? bus1.op_ready : bus3.op_ready;
  endfunction
  function automatic logic g_rv(input int s);
    return (s == 1) ? bus1.rsp_valid : bus3.rsp_valid;
  endfunction
  function automatic logic g_rd(input int s);
    return (s == 1) ? bus1.rsp_data : bus3.rsp_data;
  endfunction
  function automatic logic [3:0] g_rop(input int s);
    return (s == 1) ? bus1.rsp_op : bus3.rsp_op;
  endfunction
  function automatic logic [3:0] g_rt(input int s);
    return (s == 1) ? rt1 : rt3;
  endfunction
  function automatic logic [3:0] g_rf(input int s);
    return (s == 1) ? rf1 : rf3;
  endfunction

  task automatic set_op(input int s, input logic v, input logic [3:0] d);
    if (s == 1) begin bus1.op_valid = v; bus1.op_data = d; end
    else begin bus3.op_valid = v; bus3.op_data = d; end
  endtask
  task automatic set_rr(input int s, input logic r);
    if (s == 1) bus1.rsp_ready = r; else bus3.rsp_ready = r;
  endtask

  // Complement invariant on every cycle (NULL rails tolerated only in the spacer build)
  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      if (rf1 !== ~rt1 && !(SPACER_BUILD && rt1 == 4'b0 && rf1 == 4'b0)) begin
        failures++;
        $display("[TB] FAIL invariant1: rail_t=%b rail_f=%b", rt1, rf1);
      end
      checks++;
      if (rf3 !== ~rt3 && !(SPACER_BUILD && rt3 == 4'b0 && rf3 == 4'b0)) begin
        failures++;
        $display("[TB] FAIL invariant3: rail_t=%b rail_f=%b", rt3, rf3);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send_op(input int s, input logic [3:0] d, input logic exp_res, output int acc);
    acc = -1;
    set_op(s, 1'b1, d);
    for (int i = 0; i < 40; i++) begin
      if (g_ready(s)) begin
        acc = cycle;
        @(posedge clk);
        if (s == 1) sb1.push_back({d, exp_res}); else sb3.push_back({d, exp_res});
        @(negedge clk);
        set_op(s, 1'b0, 4'b0000);
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      checks++; failures++;
      set_op(s, 1'b0, 4'b0000);
      $display("[TB] FAIL accept_timeout dut%0d: op_ready never seen, required 1", s);
    end
  endtask

  // Waits for a response, checks it against the scoreboard, completes the handshake.
  task automatic recv_rsp(input int s, input int acc, input int exp_lat, input logic chk_lat);
    logic       got;
    logic [4:0] e;
    got = 1'b0;
    set_rr(s, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (g_rv(s)) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      failures++;
      $display("[TB] FAIL rsp_timeout dut%0d: rsp_valid=0 required 1", s);
      set_rr(s, 1'b0);
      return;
    end
    if (chk_lat) begin
      checks++;
      if (cycle - acc != exp_lat) begin
        failures++;
        $display("[TB] FAIL latency dut%0d: got %0d required %0d", s, cycle - acc, exp_lat);
      end
    end
    checks++;
    if (g_ready(s) !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ready_in_resp dut%0d: op_ready=%b required 0", s, g_ready(s));
    end
    checks++;
    if ((s == 1 ? sb1.size() : sb3.size()) == 0) begin
      failures++;
      $display("[TB] FAIL unexpected_rsp dut%0d: op=%b with empty scoreboard", s, g_rop(s));
    end else begin
      e = (s == 1) ? sb1.pop_front() : sb3.pop_front();
      checks++;
      if (g_rd(s) !== e[0]) begin
        failures++;
        $display("[TB] FAIL rsp_data dut%0d op=%b: got %b required %b", s, e[4:1], g_rd(s), e[0]);
      end
      checks++;
      if (g_rop(s) !== e[4:1]) begin
        failures++;
        $display("[TB] FAIL rsp_op dut%0d: got %b required %b", s, g_rop(s), e[4:1]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (g_rv(s) !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rsp_clear dut%0d: rsp_valid=%b required 0", s, g_rv(s));
    end
    checks++;
    if (g_ready(s) !== !SPACER_BUILD) begin
      failures++;
      $display("[TB] FAIL ready_after dut%0d: op_ready=%b required %b", s, g_ready(s), !SPACER_BUILD);
    end
    set_rr(s, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 1; s <= 3; s += 2) begin
      checks++;
      if (g_rt(s) !== 4'b0000 || g_rf(s) !== 4'b1111) begin
        failures++;
        $display("[TB] FAIL reset_rails dut%0d: got %b/%b required 0000/1111", s, g_rt(s), g_rf(s));
      end
      checks++;
      if (g_ready(s) !== 1'b1 || g_rv(s) !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_hs dut%0d: ready=%b valid=%b required 1/0", s, g_ready(s), g_rv(s));
      end
      checks++;
      if (g_rd(s) !== 1'b0 || g_rop(s) !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL reset_rsp dut%0d: data=%b op=%b required 0/0000", s, g_rd(s), g_rop(s));
      end
    end
  endtask

  task automatic test_single_op();
    int acc;
    send_op(3, 4'b1010, 1'b1, acc);
    checks++;
    if (rt3 !== 4'b1010 || rf3 !== 4'b0101) begin
      failures++;
      $display("[TB] FAIL single_rails: got %b/%b required 1010/0101", rt3, rf3);
    end
    checks++;
    if (bus3.op_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_ready_drop: op_ready=%b required 0", bus3.op_ready);
    end
    recv_rsp(3, acc, 4, 1'b1);
  endtask

  task automatic test_function();
    logic [3:0] ops [5] = '{4'b0000, 4'b0001, 4'b0100, 4'b1100, 4'b0101};
    logic       res [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int acc;
    for (int i = 0; i < 5; i++) begin
      send_op(3, ops[i], res[i], acc);
      recv_rsp(3, acc, 4, 1'b1);
`ifdef DR_SPACER_EN
      repeat (3) @(negedge clk);
`endif
    end
  endtask

  task automatic test_backpressure();
    int   acc;
    logic got;
    got = 1'b0;
    send_op(3, 4'b1100, 1'b1, acc);
    for (int i = 0; i < 40; i++) begin
      if (bus3.rsp_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      failures++;
      $display("[TB] FAIL bp_timeout: rsp_valid=0 required 1");
    end
    set_op(3, 1'b1, 4'b0101);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus3.rsp_valid !== 1'b1 || bus3.rsp_data !== 1'b1 || bus3.rsp_op !== 4'b1100) begin
        failures++;
        $display("[TB] FAIL bp_hold: valid=%b data=%b op=%b required 1/1/1100",
                 bus3.rsp_valid, bus3.rsp_data, bus3.rsp_op);
      end
      checks++;
      if (rt3 !== 4'b1100 || rf3 !== 4'b0011 || bus3.op_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp_rails: rails=%b/%b ready=%b required 1100/0011/0", rt3, rf3, bus3.op_ready);
      end
    end
    set_op(3, 1'b0, 4'b0000);
    recv_rsp(3, acc, 0, 1'b0);
`ifdef DR_SPACER_EN
    repeat (3) @(negedge clk);
`endif
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [3] = '{4'b0000, 4'b1111, 4'b0110};
    int acc;
    for (int i = 0; i < 3; i++) begin
      send_op(1, ops[i], eval_model(ops[i]), acc);
      recv_rsp(1, acc, 2, 1'b1);
    end
`ifdef DR_SPACER_EN
    repeat (3) @(negedge clk);
`endif
  endtask

`ifdef DR_SPACER_EN
  task automatic test_spacer();
    int acc;
    send_op(1, 4'b1001, 1'b0, acc);
    recv_rsp(1, acc, 2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rt1 !== 4'b0000 || rf1 !== 4'b0000 || bus1.op_ready !== (i == 2)) begin
        failures++;
        $display("[TB] FAIL spacer_phase%0d: rails=%b/%b ready=%b required 0000/0000/%0d",
                 i, rt1, rf1, bus1.op_ready, (i == 2));
      end
      if (i < 2) @(negedge clk);
    end
    send_op(1, 4'b0011, 1'b0, acc);
    checks++;
    if (rt1 !== 4'b0011 || rf1 !== 4'b1100) begin
      failures++;
      $display("[TB] FAIL spacer_next_rails: got %b/%b required 0011/1100", rt1, rf1);
    end
    recv_rsp(1, acc, 2, 1'b1);
    repeat (3) @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid_drive();
    int acc;
    send_op(3, 4'b0110, 1'b1, acc);
    inv_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rt3 !== 4'b0000 || rf3 !== 4'b1111 || bus3.op_ready !== 1'b1 || bus3.rsp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset: rails=%b/%b ready=%b valid=%b required 0000/1111/1/0",
               rt3, rf3, bus3.op_ready, bus3.rsp_valid);
    end
    checks++;
    if (bus3.rsp_op !== 4'b0000 || bus3.rsp_data !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset_rsp: op=%b data=%b required 0000/0", bus3.rsp_op, bus3.rsp_data);
    end
    sb3.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_rr(3, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus3.rsp_valid !== 1'b0 || bus3.op_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL no_partial_rsp: valid=%b ready=%b required 0/1", bus3.rsp_valid, bus3.op_ready);
      end
    end
    set_rr(3, 1'b0);
  endtask

  initial begin
    set_op(1, 1'b0, 4'b0000);
    set_op(3, 1'b0, 4'b0000);
    set_rr(1, 1'b0);
    set_rr(3, 1'b0);
    test_reset();
    inv_en = 1'b1;
    test_single_op();
    test_function();
    test_backpressure();
    test_back_to_back();
`ifdef DR_SPACER_EN
    test_spacer();
`endif
    test_reset_mid_drive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
